// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: the funct3 access formats, the
// controller state type and small decode helpers for a request's format.
// ---------------------------------------------------------------------------
package lsu_pkg;

    // funct3 access formats as seen on the core and memory interfaces
    localparam logic [2:0] FMT_B  = 3'b000;
    localparam logic [2:0] FMT_H  = 3'b001;
    localparam logic [2:0] FMT_W  = 3'b010;
    localparam logic [2:0] FMT_BU = 3'b100;
    localparam logic [2:0] FMT_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Access size in bytes; the low two funct3 bits carry the width
    function automatic logic [2:0] fmt_size(input logic [2:0] fmt);
        case (fmt[1:0])
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // 011 and 11x are not defined; unsigned variants only make sense for loads
    function automatic logic fmt_illegal(input logic [2:0] fmt, input logic we);
        return (fmt[1:0] == 2'b11) || (fmt[2:1] == 2'b11) || (we && fmt[2]);
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// ---------------------------------------------------------------------------
// lsu_extend
// Purely combinational sign/zero extension of an assembled little-endian load
// word according to its funct3 format. Shared with the writeback path.
// Ports:
//   fmt_i  [2:0]  funct3 load format
//   data_i [31:0] raw assembled word (access bytes in the low lanes)
//   data_o [31:0] extended result
// ---------------------------------------------------------------------------
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (fmt_i)
            FMT_B:   data_o = {{24{data_i[7]}}, data_i[7:0]};
            FMT_H:   data_o = {{16{data_i[15]}}, data_i[15:0]};
            FMT_BU:  data_o = {24'b0, data_i[7:0]};
            FMT_HU:  data_o = {16'b0, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu
// Load/store unit on the initiator side of the data-memory port. Accepts one
// request per handshake, performs it as a single aligned beat or as a run of
// byte beats when misaligned, and returns a held, extended response.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_req_valid/o_req_ready        request handshake
//   i_req_we/fmt/addr/wdata        request: store flag, funct3, address, data
//   o_rsp_valid/i_rsp_ready        response handshake (held until accepted)
//   o_rsp_rdata/o_rsp_err          extended load data, error flag
//   o_mem_addr/fmt/r_en/w_en/w_data memory command, one beat per cycle
//   i_mem_r_data                   combinational memory read data
// ---------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE         = 1024,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_fmt,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_mem_addr,
    output logic [2:0]  o_mem_fmt,
    output logic        o_mem_r_en,
    output logic        o_mem_w_en,
    output logic [31:0] o_mem_w_data,
    input  logic [31:0] i_mem_r_data
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  fmt_q, fmt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        split_q, split_d;
    logic [1:0]  beat_q, beat_d;

    logic [2:0]  reqSize;
    logic [32:0] reqLastByte;
    logic        reqMisaligned;
    logic        reqErr;
    logic [2:0]  curSize;
    logic        lastBeat;
    logic [31:0] extData;

    // Request screening; the last byte is computed one bit wider so an
    // address near 2^32 cannot wrap back into range.
    assign reqSize       = fmt_size(i_req_fmt);
    assign reqLastByte   = {1'b0, i_req_addr} + {30'b0, reqSize} - 33'd1;
    assign reqMisaligned = (reqSize == 3'd2) ? i_req_addr[0] :
                           (reqSize == 3'd4) ? (i_req_addr[1:0] != 2'b00) : 1'b0;
    assign reqErr        = fmt_illegal(i_req_fmt, i_req_we)
                         || (reqLastByte >= 33'(MEM_SIZE))
                         || (reqMisaligned && !ALLOW_MISALIGNED);

    // An aligned access is a single beat; a split one ends on byte size-1
    assign curSize  = fmt_size(fmt_q);
    assign lastBeat = !split_q || ({1'b0, beat_q} == (curSize - 3'd1));

    lsu_extend u_extend (
        .fmt_i  (fmt_q),
        .data_i (data_q),
        .data_o (extData)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            fmt_q   <= 3'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            data_q  <= 32'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            beat_q  <= 2'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            fmt_q   <= fmt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
            split_q <= split_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        fmt_d   = fmt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
        split_d = split_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    fmt_d   = i_req_fmt;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    data_d  = 32'b0;
                    beat_d  = 2'b0;
                    err_d   = reqErr;
                    split_d = reqMisaligned;
                    state_d = reqErr ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                // Split loads assemble one byte per beat into byte lane k
                if (!we_q) begin
                    if (split_q) begin
                        data_d[{beat_q, 3'b000} +: 8] = i_mem_r_data[7:0];
                    end else begin
                        data_d = i_mem_r_data;
                    end
                end
                if (lastBeat) begin
                    state_d = RESP;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory command is driven only while a beat is in flight
    always_comb begin
        o_mem_addr   = 32'b0;
        o_mem_fmt    = 3'b0;
        o_mem_r_en   = 1'b0;
        o_mem_w_en   = 1'b0;
        o_mem_w_data = 32'b0;
        if (state_q == ACCESS) begin
            o_mem_r_en = !we_q;
            o_mem_w_en = we_q;
            if (split_q) begin
                o_mem_addr   = addr_q + {30'b0, beat_q};
                o_mem_fmt    = we_q ? FMT_B : FMT_BU;
                o_mem_w_data = {24'b0, wdata_q[{beat_q, 3'b000} +: 8]};
            end else begin
                o_mem_addr   = addr_q;
                o_mem_fmt    = fmt_q;
                o_mem_w_data = wdata_q;
            end
        end
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_rsp_valid = (state_q == RESP);
    assign o_rsp_err   = (state_q == RESP) && err_q;
    assign o_rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? extData : 32'b0;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu
// Self-checking bench for the load/store unit: a byte-array memory model,
// a table of directed vectors, hand-written multi-cycle sequences and a
// randomized phase checked against a byte-level reference model.
// ---------------------------------------------------------------------------
module tb_lsu;
    import lsu_pkg::*;

    localparam int MEM_BYTES = 1024;

    logic        clock = 1'b0;
    logic        rstN;
    logic        reqValid, reqReady, reqWe;
    logic [2:0]  reqFmt;
    logic [31:0] reqAddr, reqWdata;
    logic        rspValid, rspReady, rspErr;
    logic [31:0] rspRdata;
    logic [31:0] memAddr, memWData, memRData;
    logic [2:0]  memFmt;
    logic        memREn, memWEn;

    // Second instance with misaligned splitting disabled
    logic        reqValidB, reqReadyB, rspValidB, rspReadyB, rspErrB;
    logic [2:0]  reqFmtB;
    logic [31:0] reqAddrB, rspRdataB, memAddrB, memWDataB;
    logic [2:0]  memFmtB;
    logic        memREnB, memWEnB;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem    [0:MEM_BYTES-1];
    logic [7:0]  refMem [0:MEM_BYTES-1];
    bit          preloaded = 1'b0;

    logic [31:0] beatAddr [$];
    logic [2:0]  beatFmt  [$];
    logic [31:0] beatData [$];
    logic        beatWe   [$];

    typedef struct {
        logic        we;
        logic [2:0]  fmt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
        int          expBeats;
        string       name;
    } vec_t;

    vec_t vecs [$];

    always #5 clock = ~clock;

    lsu #(.MEM_SIZE(1024), .ALLOW_MISALIGNED(1'b1)) dut (
        .i_clk(clock), .i_rst_n(rstN),
        .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_we(reqWe),
        .i_req_fmt(reqFmt), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
        .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
        .o_rsp_rdata(rspRdata), .o_rsp_err(rspErr),
        .o_mem_addr(memAddr), .o_mem_fmt(memFmt), .o_mem_r_en(memREn),
        .o_mem_w_en(memWEn), .o_mem_w_data(memWData), .i_mem_r_data(memRData)
    );

    lsu #(.MEM_SIZE(1024), .ALLOW_MISALIGNED(1'b0)) dutB (
        .i_clk(clock), .i_rst_n(rstN),
        .i_req_valid(reqValidB), .o_req_ready(reqReadyB), .i_req_we(1'b0),
        .i_req_fmt(reqFmtB), .i_req_addr(reqAddrB), .i_req_wdata(32'h0),
        .o_rsp_valid(rspValidB), .i_rsp_ready(rspReadyB),
        .o_rsp_rdata(rspRdataB), .o_rsp_err(rspErrB),
        .o_mem_addr(memAddrB), .o_mem_fmt(memFmtB), .o_mem_r_en(memREnB),
        .o_mem_w_en(memWEnB), .o_mem_w_data(memWDataB), .i_mem_r_data(32'h0)
    );

    function automatic int bytesOf(input logic [2:0] f);
        case (f[1:0])
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] initByte(input int i);
        case (i)
            'h100: return 8'h11;
            'h101: return 8'h22;
            'h102: return 8'h33;
            'h103: return 8'h44;
            'h104: return 8'h85;
            'h105: return 8'h66;
            'h106: return 8'h77;
            'h107: return 8'h88;
            default: return 8'((i * 37 + 5) & 255);
        endcase
    endfunction

    // Memory model: combinational read, write committed on the rising edge
    always_comb begin
        memRData = 32'h0;
        if (memREn) begin
            for (int k = 0; k < 4; k++) begin
                if (k < bytesOf(memFmt) && (memAddr + 32'(k)) < 32'(MEM_BYTES)) begin
                    memRData[8*k +: 8] = mem[memAddr[9:0] + 10'(k)];
                end
            end
        end
    end

    always @(posedge clock) begin
        if (!preloaded) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= initByte(i);
            preloaded <= 1'b1;
        end else if (memWEn) begin
            for (int k = 0; k < 4; k++) begin
                if (k < bytesOf(memFmt) && (memAddr + 32'(k)) < 32'(MEM_BYTES)) begin
                    mem[memAddr[9:0] + 10'(k)] <= memWData[8*k +: 8];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic giveUp(input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: no DUT event within the cycle budget", what);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] aborting after timeout");
    endtask

    // Reference: the access as a byte-level operation on an array
    task automatic refModel(input logic we, input logic [2:0] fmt, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit allowMis,
                            output logic [31:0] rdata, output logic err,
                            output int lat, output int beats);
        int     size;
        longint value;
        bit     illegal, mis;
        size    = bytesOf(fmt);
        illegal = (fmt == 3'b011) || (fmt == 3'b110) || (fmt == 3'b111) || (we && fmt >= 3'b100);
        mis     = (addr % size) != 0;
        err     = illegal || (longint'(addr) + size > MEM_BYTES) || (mis && !allowMis);
        rdata   = 32'h0;
        lat     = 1;
        beats   = 0;
        if (!err) begin
            beats = mis ? size : 1;
            lat   = beats + 1;
            if (we) begin
                for (int k = 0; k < size; k++) refMem[addr[9:0] + 10'(k)] = wdata[8*k +: 8];
            end else begin
                value = 0;
                for (int k = 0; k < size; k++) value += longint'(refMem[addr[9:0] + 10'(k)]) << (8 * k);
                if (fmt < 3'b100 && size < 4 && value >= (longint'(1) << (8 * size - 1)))
                    value -= longint'(1) << (8 * size);
                rdata = value[31:0];
            end
        end
    endtask

    // Compare the logged memory beats against what the access should issue
    task automatic checkBeats(input logic we, input logic [2:0] fmt, input logic [31:0] addr,
                              input logic [31:0] wdata, input int expBeats, input string tag);
        bit split;
        checkOutput({tag, " beat count"}, 32'(beatAddr.size()), 32'(expBeats));
        if (beatAddr.size() == expBeats) begin
            split = expBeats > 1;
            for (int k = 0; k < expBeats; k++) begin
                checkOutput({tag, " beat addr"}, beatAddr[k], split ? addr + 32'(k) : addr);
                checkOutput({tag, " beat fmt"}, 32'(beatFmt[k]),
                            32'(split ? (we ? 3'b000 : 3'b100) : fmt));
                checkOutput({tag, " beat we"}, 32'(beatWe[k]), 32'(we));
                if (we) begin
                    if (split) checkOutput({tag, " beat wdata"}, {24'h0, beatData[k][7:0]},
                                           {24'h0, wdata[8*k +: 8]});
                    else       checkOutput({tag, " beat wdata"}, beatData[k], wdata);
                end
            end
        end
    endtask

    // One full transaction; hold cycles keep rsp_ready low with a pending request
    task automatic applyStimulus(input logic we, input logic [2:0] fmt, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold,
                                 output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        beatAddr.delete(); beatFmt.delete(); beatData.delete(); beatWe.delete();
        @(negedge clock);
        reqValid = 1'b1; reqWe = we; reqFmt = fmt; reqAddr = addr; reqWdata = wdata;
        rspReady = 1'b0;
        guard = 0;
        while (!reqReady) begin
            if (guard == 20) giveUp("req_ready wait");
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        #1 reqValid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (memREn || memWEn) begin
                beatAddr.push_back(memAddr);
                beatFmt.push_back(memFmt);
                beatData.push_back(memWData);
                beatWe.push_back(memWEn);
            end
            if (lat > 20) giveUp("rsp_valid wait");
        end while (!rspValid);
        rdata = rspRdata;
        err   = rspErr;
        checkOutput("req_ready in RESP", 32'(reqReady), 32'h0);
        for (int h = 0; h < hold; h++) begin
            reqValid = 1'b1; reqWe = 1'b1; reqFmt = FMT_W; reqAddr = 32'h3F0; reqWdata = $urandom;
            @(negedge clock);
            checkOutput("rsp_valid held", 32'(rspValid), 32'h1);
            checkOutput("rsp_rdata held", rspRdata, rdata);
            checkOutput("rsp_err held", 32'(rspErr), 32'(err));
            checkOutput("req_ready while pending", 32'(reqReady), 32'h0);
            checkOutput("mem idle in RESP", 32'({memREn, memWEn}), 32'h0);
        end
        rspReady = 1'b1;
        @(posedge clock);
        #1;
        rspReady = 1'b0;
        reqValid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, expR;
        logic        er, expE;
        int          lat, expLat, expBeats, diffs;
        logic [2:0]  fmtPool [5];
        logic        rWe;
        logic [2:0]  rFmt;
        logic [31:0] rAddr, rData;

        fmtPool = '{FMT_B, FMT_H, FMT_W, FMT_BU, FMT_HU};
        for (int i = 0; i < MEM_BYTES; i++) refMem[i] = initByte(i);

        rstN = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqFmt = 3'b0; reqAddr = 32'h0;
        reqWdata = 32'h0; rspReady = 1'b0;
        reqValidB = 1'b0; reqFmtB = 3'b0; reqAddrB = 32'h0; rspReadyB = 1'b0;
        repeat (3) @(negedge clock);
        rstN = 1'b1;
        @(negedge clock);
        checkOutput("reset req_ready", 32'(reqReady), 32'h1);
        checkOutput("reset rsp_valid/err", 32'({rspValid, rspErr}), 32'h0);
        checkOutput("reset rsp_rdata", rspRdata, 32'h0);
        checkOutput("reset mem enables/fmt", 32'({memREn, memWEn, memFmt}), 32'h0);
        checkOutput("reset mem addr", memAddr, 32'h0);
        checkOutput("reset mem wdata", memWData, 32'h0);

        // LB with a stalled response and a pending request behind it
        refModel(1'b0, FMT_B, 32'h104, 32'h0, 1'b1, expR, expE, expLat, expBeats);
        applyStimulus(1'b0, FMT_B, 32'h104, 32'h0, 3, rd, er, lat);
        checkOutput("LB stall rdata", rd, 32'hFFFFFF85);
        checkOutput("LB stall err", 32'(er), 32'h0);
        checkOutput("LB stall latency", 32'(lat), 32'd2);
        @(negedge clock);
        checkOutput("req_ready after handshake", 32'(reqReady), 32'h1);

        vecs.push_back('{1'b0, FMT_W,  32'h100, 32'h0,        32'h44332211, 1'b0, 2, 1, "LW 0x100"});
        vecs.push_back('{1'b0, FMT_H,  32'h103, 32'h0,        32'hFFFF8544, 1'b0, 3, 2, "LH 0x103"});
        vecs.push_back('{1'b0, FMT_HU, 32'h103, 32'h0,        32'h00008544, 1'b0, 3, 2, "LHU 0x103"});
        vecs.push_back('{1'b1, FMT_W,  32'h101, 32'hDEADBEEF, 32'h0,        1'b0, 5, 4, "SW 0x101"});
        vecs.push_back('{1'b0, FMT_W,  32'h100, 32'h0,        32'hADBEEF11, 1'b0, 2, 1, "LW 0x100 after SW"});
        vecs.push_back('{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0, "fmt 011"});
        vecs.push_back('{1'b0, FMT_W,  32'h3FE, 32'h0,        32'h0,        1'b1, 1, 0, "LW 0x3FE range"});
        vecs.push_back('{1'b0, FMT_H,  32'h3FF, 32'h0,        32'h0,        1'b1, 1, 0, "LH 0x3FF range"});
        vecs.push_back('{1'b0, FMT_BU, 32'h107, 32'h0,        32'h00000088, 1'b0, 2, 1, "LBU 0x107"});
        vecs.push_back('{1'b1, FMT_B,  32'h3FF, 32'h0000005A, 32'h0,        1'b0, 2, 1, "SB 0x3FF"});
        vecs.push_back('{1'b0, FMT_B,  32'h3FF, 32'h0,        32'h0000005A, 1'b0, 2, 1, "LB 0x3FF"});
        vecs.push_back('{1'b1, FMT_BU, 32'h010, 32'h12345678, 32'h0,        1'b1, 1, 0, "store fmt BU"});
        vecs.push_back('{1'b0, 3'b110, 32'h010, 32'h0,        32'h0,        1'b1, 1, 0, "fmt 110"});
        vecs.push_back('{1'b0, FMT_H,  32'h102, 32'h0,        32'hFFFFADBE, 1'b0, 2, 1, "LH 0x102"});

        for (int i = 0; i < vecs.size(); i++) begin
            refModel(vecs[i].we, vecs[i].fmt, vecs[i].addr, vecs[i].wdata, 1'b1,
                     expR, expE, expLat, expBeats);
            applyStimulus(vecs[i].we, vecs[i].fmt, vecs[i].addr, vecs[i].wdata, 0, rd, er, lat);
            checkOutput({vecs[i].name, " rdata"}, rd, vecs[i].expRdata);
            checkOutput({vecs[i].name, " err"}, 32'(er), 32'(vecs[i].expErr));
            checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].expLat));
            checkBeats(vecs[i].we, vecs[i].fmt, vecs[i].addr, vecs[i].wdata,
                       vecs[i].expBeats, vecs[i].name);
        end

        // Misaligned LH is an error when splitting is disabled
        @(negedge clock);
        reqValidB = 1'b1; reqFmtB = FMT_H; reqAddrB = 32'h101;
        @(posedge clock);
        #1 reqValidB = 1'b0;
        @(negedge clock);
        checkOutput("noSplit LH 0x101 valid/err", 32'({rspValidB, rspErrB}), 32'h3);
        checkOutput("noSplit LH 0x101 rdata", rspRdataB, 32'h0);
        checkOutput("noSplit LH 0x101 mem enables", 32'({memREnB, memWEnB}), 32'h0);
        rspReadyB = 1'b1;
        @(posedge clock);
        #1 rspReadyB = 1'b0;
        reqValidB = 1'b1; reqFmtB = FMT_H; reqAddrB = 32'h102;
        @(posedge clock);
        #1 reqValidB = 1'b0;
        @(negedge clock);
        checkOutput("noSplit LH 0x102 read beat", 32'({memREnB, rspValidB}), 32'h2);
        @(negedge clock);
        checkOutput("noSplit LH 0x102 valid/err", 32'({rspValidB, rspErrB}), 32'h2);
        rspReadyB = 1'b1;
        @(posedge clock);
        #1 rspReadyB = 1'b0;

        // Reset after two beats of a split SW: only the first two bytes land
        @(negedge clock);
        reqValid = 1'b1; reqWe = 1'b1; reqFmt = FMT_W; reqAddr = 32'h101; reqWdata = 32'h0BADF00D;
        @(posedge clock);
        #1 reqValid = 1'b0;
        repeat (2) @(posedge clock);
        #1 rstN = 1'b0;
        refMem[10'h101] = 8'h0D;
        refMem[10'h102] = 8'hF0;
        repeat (2) begin
            @(negedge clock);
            checkOutput("reset abort rsp_valid", 32'(rspValid), 32'h0);
            checkOutput("reset abort w_en", 32'(memWEn), 32'h0);
        end
        rstN = 1'b1;
        @(negedge clock);
        checkOutput("req_ready after release", 32'(reqReady), 32'h1);
        checkOutput("rsp_valid after release", 32'(rspValid), 32'h0);
        checkOutput("bytes 0x101..0x104 after abort",
                    {mem[10'h104], mem[10'h103], mem[10'h102], mem[10'h101]}, 32'hDEADF00D);

        // Randomized traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            rWe   = 1'($urandom_range(0, 1));
            rFmt  = ($urandom_range(0, 9) < 8) ? fmtPool[$urandom_range(0, 4)] : 3'($urandom);
            rAddr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1016, 1040))
                                                : 32'($urandom_range(0, 1023));
            rData = $urandom;
            refModel(rWe, rFmt, rAddr, rData, 1'b1, expR, expE, expLat, expBeats);
            applyStimulus(rWe, rFmt, rAddr, rData, $urandom_range(0, 2), rd, er, lat);
            checkOutput($sformatf("rand%0d rdata", i), rd, expR);
            checkOutput($sformatf("rand%0d err", i), 32'(er), 32'(expE));
            checkOutput($sformatf("rand%0d latency", i), 32'(lat), 32'(expLat));
            checkBeats(rWe, rFmt, rAddr, rData, expBeats, $sformatf("rand%0d", i));
        end

        @(negedge clock);
        diffs = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== refMem[i]) diffs++;
        checkOutput("memory image differing bytes", 32'(diffs), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator side of the data-memory port. Accepts one load or store per handshake from the core's execute stage and drives the memory's address, format, read-enable, write-enable and write-data inputs. Misaligned halfword and word accesses are split into sequential byte accesses, and load results are sign- or zero-extended before a held response goes back to the core. Sits between the core pipeline and the data-memory instance.

## Interface
- MEM_SIZE, 1024: memory size in bytes. Any access with byte address ≥ MEM_SIZE is an error.
- ALLOW_MISALIGNED, 1: 1 = split misaligned accesses into byte beats; 0 = report misaligned accesses as errors.
- i_clk in 1: clock, rising edge.
- i_rst_n in 1: reset, asynchronous, active-low.
- i_req_valid in 1: request valid.
- o_req_ready out 1: unit can accept a request.
- i_req_we in 1: 1 = store, 0 = load.
- i_req_fmt in 3: funct3 encoding. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_req_addr in 32: byte address.
- i_req_wdata in 32: store data, little-endian.
- o_rsp_valid out 1: response valid; held until accepted.
- i_rsp_ready in 1: core accepts the response.
- o_rsp_rdata out 32: extended load data. Zero for stores and for errors.
- o_rsp_err out 1: request was illegal, misaligned with ALLOW_MISALIGNED=0, or out of range.
- o_mem_addr out 32: memory byte address.
- o_mem_fmt out 3: memory access format.
- o_mem_r_en out 1: memory read enable. Memory read data is combinational.
- o_mem_w_en out 1: memory write enable. Memory commits the write on the rising edge.
- o_mem_w_data out 32: memory write data.
- i_mem_r_data in 32: memory read data, valid in the same cycle as o_mem_r_en.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset puts the FSM in IDLE.
- IDLE
  - o_req_ready = 1.
  - On i_req_valid & o_req_ready, latch we, fmt, addr and wdata.
  - Compute size: 1 for B/BU, 2 for H/HU, 4 for W.
  - Go to RESP with err = 1 and no memory access if any of these hold:
    - illegal fmt: 011, 11x, or a store with fmt[2] = 1;
    - addr + size − 1 ≥ MEM_SIZE;
    - addr misaligned for size and ALLOW_MISALIGNED = 0.
  - Otherwise go to ACCESS.
- Aligned access: one beat. o_mem_addr = addr, o_mem_fmt = fmt.
- Misaligned access: size beats, k = 0..size−1.
  - o_mem_addr = addr + k.
  - o_mem_fmt = 100 for loads, 000 for stores.
  - o_mem_w_data[7:0] = wdata byte k.
- ACCESS
  - Exactly one beat per cycle.
  - o_mem_r_en = !we; o_mem_w_en = we.
  - Loads capture i_mem_r_data: the full 32 bits for an aligned beat, bits [7:0] into assembly byte k for a split beat.
  - A beat counter (2 bits) advances each cycle. After the last beat, go to RESP.
- RESP
  - o_rsp_valid = 1.
  - Load data is extended per fmt: B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
  - Hold all response outputs stable until i_rsp_ready, then go to IDLE.
- Memory outputs outside ACCESS: enables = 0, address/fmt/data = 0.

## Timing
- Request accepted at edge N.
  - Aligned: ACCESS in cycle N+1; o_rsp_valid from N+2.
  - Split H: o_rsp_valid from N+3.
  - Split W: o_rsp_valid from N+5.
  - Error: o_rsp_valid from N+1.
- Response handshake completes on the edge where o_rsp_valid & i_rsp_ready. The next request can be accepted no earlier than the following edge, because o_req_ready = 0 in ACCESS and RESP.
- No back-to-back overlap; at most one request is outstanding.
- All outputs are derived from registered state. There is no combinational path from i_req_* or i_rsp_ready to any output.
- Reset values: state IDLE, o_req_ready 1 once reset is released, o_rsp_valid 0, o_rsp_rdata 0, o_rsp_err 0, all o_mem_* 0.
- Reset mid-operation aborts immediately:
  - bytes already written by a split store remain in memory;
  - no response is produced.
- i_req_valid during ACCESS/RESP is ignored. The core must hold the request until ready.

## Structure
- Package lsu_pkg:
  - fmt constants FMT_B, FMT_H, FMT_W, FMT_BU, FMT_HU;
  - state enum {IDLE, ACCESS, RESP};
  - size-decode function.
- Sub-module lsu_extend: combinational extension of the assembled 32-bit word by fmt. Reused by the writeback path.

## Test plan
Preload memory bytes 0x100..0x107 = 11 22 33 44 85 66 77 88.
1. LW 0x100 → one r_en cycle at 0x100 with fmt 010; rdata 0x44332211, err 0; o_rsp_valid 2 cycles after accept.
2. LH 0x103 → two byte reads at 0x103 and 0x104 with fmt 100; rdata 0xFFFF8544. LHU 0x103 → 0x00008544. o_rsp_valid 3 cycles after accept.
3. SW 0x101, data 0xDEADBEEF → four byte writes EF, BE, AD, DE at 0x101..0x104; a following LW 0x100 → 0xADBEEF11.
4. Error cases, each with err 1, rdata 0, and no memory enable asserted:
   - fmt 011 at 0x100;
   - LW 0x3FE with MEM_SIZE 1024;
   - LH 0x101 with ALLOW_MISALIGNED 0.
5. LB 0x104 with i_rsp_ready held low for 3 cycles → o_rsp_valid and rdata 0xFFFFFF85 stable throughout; o_req_ready 0 and a pending request not accepted until the cycle after the handshake.
6. Assert reset after 2 beats of SW 0x101 → only 0x101 and 0x102 modified; o_rsp_valid never asserts; o_req_ready 1 after release.
